mux_tree_lut_reg: RTL and testbench

//  Parametrised successor of the fixed 8-input fabric wide-mux primitive: a 2**LEVELS-input

---
 rtl/mux_tree_lut_reg.sv | 140 ++++++++++++++
 tb/tb_mux_tree_lut_reg.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_tree_lut_reg.sv
// Purpose: 2**LEVELS-input binary mux tree with one tap per level, optional tap registers and a fully pipelined mode.
// Latency: 0 (comb tap), 1 (registered tap) or l+1 cycles for tap l in pipelined mode.
// Backpressure: none; EN=0 stalls every register, SR (when enabled) overrides EN and loads INIT.
module mux_tree_lut_reg #(
  parameter int LEVELS       = 4,
  parameter int NoConfigBits = 7
) (
  input  logic                     UserCLK,
  input  logic                     RST,
  input  logic [(2**LEVELS)-1:0]   I,
  input  logic [LEVELS-1:0]        S,
  input  logic                     EN,
  input  logic                     SR,
  output logic [LEVELS-1:0]        M,
  input  logic [NoConfigBits-1:0]  ConfigBits
);

  localparam int W = 2**LEVELS;

  // Static configuration fields.
  logic [LEVELS-1:0] reg_sel;
  logic              pipe_mode;
  logic              init_val;
  logic              sr_en;
  logic              sr_load;

  assign reg_sel   = ConfigBits[LEVELS-1:0];
  assign pipe_mode = ConfigBits[LEVELS];
  assign init_val  = ConfigBits[LEVELS+1];
  assign sr_en     = ConfigBits[LEVELS+2];
  assign sr_load   = sr_en & SR;

  // Combinational taps, tap registers, delayed selects.
  logic [LEVELS-1:0] tap_comb;
  logic [LEVELS-1:0] tap_q;
  logic [LEVELS-1:0] sd_tap;

  // Pipeline node storage: all levels packed back to back.
  // Level l occupies W>>(l+1) bits starting at offset W - (W>>l).
  logic [W-2:0] pq_all;
  logic [W-2:0] pn_all;

  // Combinational tree: reduce I level by level, tapping mux 0 of each level.
  always_comb begin
    logic [W-1:0] lvl;
    logic [W-1:0] nxt;
    tap_comb = '0;
    lvl      = I;
    nxt      = '0;
    for (int l = 0; l < LEVELS; l++) begin
      nxt = '0;
      for (int j = 0; j < (W >> (l + 1)); j++) begin
        nxt[j] = S[l] ? lvl[2*j+1] : lvl[2*j];
      end
      lvl         = nxt;
      tap_comb[l] = lvl[0];
    end
  end

  // Level 0 of the pipeline uses S[0] undelayed.
  assign sd_tap[0] = S[0];

  // Per-level select delay chains: S[l] is delayed l cycles to meet its data.
  genvar gl;
  generate
    for (gl = 1; gl < LEVELS; gl++) begin : g_sd
      logic [gl-1:0] sd_q;

      // Shift S[gl] through gl stages; frozen when EN=0, preset by SR.
      always_ff @(posedge UserCLK or posedge RST) begin
        if (RST) begin
          sd_q <= '0;
        end else if (sr_load) begin
          sd_q <= {gl{init_val}};
        end else if (EN) begin
          sd_q[0] <= S[gl];
          for (int k = 1; k < gl; k++) begin
            sd_q[k] <= sd_q[k-1];
          end
        end
      end

      assign sd_tap[gl] = sd_q[gl-1];
    end
  endgenerate

  // Next-state of every pipeline node: level 0 from I, deeper levels from the previous stage registers.
  always_comb begin
    int off;
    int prev;
    pn_all = '0;
    for (int j = 0; j < (W >> 1); j++) begin
      pn_all[j] = sd_tap[0] ? I[2*j+1] : I[2*j];
    end
    for (int l = 1; l < LEVELS; l++) begin
      off  = W - (W >> l);
      prev = off - (W >> l);
      for (int j = 0; j < (W >> (l + 1)); j++) begin
        pn_all[off+j] = sd_tap[l] ? pq_all[prev+2*j+1] : pq_all[prev+2*j];
      end
    end
  end

  // Pipeline stage registers for all mux outputs.
  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      pq_all <= '0;
    end else if (sr_load) begin
      pq_all <= {(W-1){init_val}};
    end else if (EN) begin
      pq_all <= pn_all;
    end
  end

  // Tap registers used in comb mode when REG[l] is set.
  always_ff @(posedge UserCLK or posedge RST) begin
    if (RST) begin
      tap_q <= '0;
    end else if (sr_load) begin
      tap_q <= {LEVELS{init_val}};
    end else if (EN) begin
      tap_q <= tap_comb;
    end
  end

  // Output select: pipelined node 0 of each level, or registered / direct comb tap.
  always_comb begin
    M = '0;
    for (int l = 0; l < LEVELS; l++) begin
      if (pipe_mode) begin
        M[l] = pq_all[W - (W >> l)];
      end else if (reg_sel[l]) begin
        M[l] = tap_q[l];
      end else begin
        M[l] = tap_comb[l];
      end
    end
  end

endmodule

// File: tb/tb_mux_tree_lut_reg.sv
// Bench for mux_tree_lut_reg with LEVELS=4: directed vectors, hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled from then on, away from the edge.
// Each task checks its own scenario inline and steps the shared error/check counters.
module tb_mux_tree_lut_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  sel;
  logic        en;
  logic        sr;
  logic [3:0]  taps;
  logic [6:0]  cfg;

  int errors = 0;
  int checks = 0;

  // Stimulus tables for the pipelined stream (vector k is sampled on edge k+1).
  logic [15:0] pv_i [8];
  logic [3:0]  pv_s [8];
  logic [3:0]  pv_m [8];
  logic [15:0] st_i [11];
  logic [3:0]  st_s [11];
  logic        st_en [11];
  logic [3:0]  st_m [11];

  always #5 clk = ~clk;

  mux_tree_lut_reg #(
    .LEVELS      (4),
    .NoConfigBits(7)
  ) dut (
    .UserCLK   (clk),
    .RST       (rst),
    .I         (data),
    .S         (sel),
    .EN        (en),
    .SR        (sr),
    .M         (taps),
    .ConfigBits(cfg)
  );

  function automatic logic [6:0] mk_cfg(logic sr_enable, logic init, logic pipe, logic [3:0] reg_en);
    return {sr_enable, init, pipe, reg_en};
  endfunction

  task automatic test_reset();
    rst  = 1'b1;
    en   = 1'b0;
    sr   = 1'b0;
    data = 16'hFFFF;
    sel  = 4'h0;
    cfg  = mk_cfg(1'b0, 1'b0, 1'b1, 4'b0000);
    #1;
    checks++;
    if (taps !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pipe: M=%b expected %b", taps, 4'b0000);
    end
    cfg = mk_cfg(1'b0, 1'b0, 1'b0, 4'b1111);
    #1;
    checks++;
    if (taps !== 4'b0000) begin
      errors++;
      $display("FAIL reset_regtaps: M=%b expected %b", taps, 4'b0000);
    end
    cfg = mk_cfg(1'b0, 1'b0, 1'b0, 4'b0000);
    #1;
    checks++;
    if (taps !== 4'b1111) begin
      errors++;
      $display("FAIL reset_combtaps: M=%b expected %b", taps, 4'b1111);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_comb();
    logic [3:0] want;
    cfg  = mk_cfg(1'b0, 1'b0, 1'b0, 4'b0000);
    en   = 1'b1;
    sr   = 1'b0;
    data = 16'hA5C3;
    for (int k = 0; k < 16; k++) begin
      sel = k[3:0];
      #1;
      // Tap l picks I at the index formed by S[l:0].
      for (int l = 0; l < 4; l++) begin
        want[l] = data[k & ((2 << l) - 1)];
      end
      checks++;
      if (taps !== want) begin
        errors++;
        $display("FAIL comb_s%0d: M=%b expected %b", k, taps, want);
      end
    end
  endtask

  task automatic test_reg_taps();
    cfg  = mk_cfg(1'b0, 1'b0, 1'b0, 4'b1010);
    en   = 1'b1;
    sr   = 1'b0;
    data = 16'h0000;
    sel  = 4'h0;
    @(posedge clk);
    #1;
    checks++;
    if (taps !== 4'b0000) begin
      errors++;
      $display("FAIL reg_clear: M=%b expected %b", taps, 4'b0000);
    end
    data = 16'h0002;
    sel  = 4'h1;
    #1;
    checks++;
    if (taps !== 4'b0101) begin
      errors++;
      $display("FAIL reg_before_edge: M=%b expected %b", taps, 4'b0101);
    end
    @(posedge clk);
    #1;
    checks++;
    if (taps !== 4'b1111) begin
      errors++;
      $display("FAIL reg_after_edge: M=%b expected %b", taps, 4'b1111);
    end
    data = 16'h0000;
    #1;
    checks++;
    if (taps !== 4'b1010) begin
      errors++;
      $display("FAIL reg_hold_until_edge: M=%b expected %b", taps, 4'b1010);
    end
    @(posedge clk);
    #1;
    checks++;
    if (taps !== 4'b0000) begin
      errors++;
      $display("FAIL reg_reload: M=%b expected %b", taps, 4'b0000);
    end
  endtask

  task automatic flush_pipe(input string name);
    cfg  = mk_cfg(1'b0, 1'b0, 1'b1, 4'b0000);
    en   = 1'b1;
    sr   = 1'b0;
    data = 16'h0000;
    sel  = 4'h0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (taps !== 4'b0000) begin
      errors++;
      $display("FAIL %s_flush: M=%b expected %b", name, taps, 4'b0000);
    end
  endtask

  task automatic test_pipe();
    pv_i = '{16'h8000, 16'h0002, 16'h0008, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    pv_s = '{4'hF, 4'h9, 4'h3, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0};
    pv_m = '{4'b0000, 4'b0001, 4'b0010, 4'b1110, 4'b0100, 4'b1100, 4'b1000, 4'b0000};
    flush_pipe("pipe");
    for (int k = 0; k < 8; k++) begin
      data = pv_i[k];
      sel  = pv_s[k];
      @(posedge clk);
      #1;
      checks++;
      if (taps !== pv_m[k]) begin
        errors++;
        $display("FAIL pipe_edge%0d: M=%b expected %b", k + 1, taps, pv_m[k]);
      end
    end
  endtask

  task automatic test_stall();
    st_i  = '{16'h8000, 16'h0002, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0008, 16'h0080,
              16'h0000, 16'h0000, 16'h0000, 16'h0000};
    st_s  = '{4'hF, 4'h9, 4'hF, 4'hF, 4'hF, 4'h3, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0};
    st_en = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    st_m  = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b1110,
              4'b0100, 4'b1100, 4'b1000, 4'b0000};
    flush_pipe("stall");
    for (int k = 0; k < 11; k++) begin
      data = st_i[k];
      sel  = st_s[k];
      en   = st_en[k];
      @(posedge clk);
      #1;
      checks++;
      if (taps !== st_m[k]) begin
        errors++;
        $display("FAIL stall_edge%0d: M=%b expected %b", k + 1, taps, st_m[k]);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_sync_reset();
    cfg  = mk_cfg(1'b1, 1'b1, 1'b1, 4'b0000);
    en   = 1'b0;
    sr   = 1'b1;
    data = 16'h0000;
    sel  = 4'h0;
    @(posedge clk);
    #1;
    checks++;
    if (taps !== 4'b1111) begin
      errors++;
      $display("FAIL sr_init1_pipe: M=%b expected %b", taps, 4'b1111);
    end
    cfg = mk_cfg(1'b1, 1'b1, 1'b0, 4'b1111);
    #1;
    checks++;
    if (taps !== 4'b1111) begin
      errors++;
      $display("FAIL sr_init1_regtaps: M=%b expected %b", taps, 4'b1111);
    end
    cfg = mk_cfg(1'b0, 1'b0, 1'b0, 4'b1111);
    @(posedge clk);
    #1;
    checks++;
    if (taps !== 4'b1111) begin
      errors++;
      $display("FAIL sr_disabled: M=%b expected %b", taps, 4'b1111);
    end
    cfg  = mk_cfg(1'b1, 1'b0, 1'b0, 4'b1111);
    en   = 1'b1;
    data = 16'hFFFF;
    @(posedge clk);
    #1;
    checks++;
    if (taps !== 4'b0000) begin
      errors++;
      $display("FAIL sr_over_en: M=%b expected %b", taps, 4'b0000);
    end
    sr = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [3:0] ramp [4];
    ramp = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    cfg  = mk_cfg(1'b0, 1'b0, 1'b1, 4'b0000);
    en   = 1'b1;
    sr   = 1'b0;
    data = 16'hFFFF;
    sel  = 4'h0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (taps !== 4'b1111) begin
      errors++;
      $display("FAIL rst_prefill: M=%b expected %b", taps, 4'b1111);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (taps !== 4'b0000) begin
      errors++;
      $display("FAIL rst_midcycle: M=%b expected %b", taps, 4'b0000);
    end
    cfg = mk_cfg(1'b0, 1'b0, 1'b0, 4'b1010);
    #2;
    checks++;
    if (taps !== 4'b0101) begin
      errors++;
      $display("FAIL rst_comb_follow: M=%b expected %b", taps, 4'b0101);
    end
    cfg = mk_cfg(1'b0, 1'b0, 1'b1, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (taps !== ramp[k]) begin
        errors++;
        $display("FAIL rst_refill%0d: M=%b expected %b", k + 1, taps, ramp[k]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_comb();
    test_reg_taps();
    test_pipe();
    test_stall();
    test_sync_reset();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
